// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: MemOp encodings (identical to
// the decoder's MemOp field), FSM states and access kinds.
package lsu_pkg;

   localparam logic [2:0] MOP_B    = 3'b000;
   localparam logic [2:0] MOP_H    = 3'b001;
   localparam logic [2:0] MOP_W    = 3'b010;
   localparam logic [2:0] MOP_BU   = 3'b100;
   localparam logic [2:0] MOP_HU   = 3'b101;
   localparam logic [2:0] MOP_NONE = 3'b111;

   typedef enum logic [1:0] {
      IDLE,
      REQ,
      WAIT,
      DONE
   } state_e;

   typedef enum logic [1:0] {
      LOAD,
      STORE,
      NONE
   } kind_e;

   // Encodings with no defined access width (011, 110).
   function automatic logic mop_undefined(input logic [2:0] mop);
      return (mop == 3'b011) || (mop == 3'b110);
   endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane steering: store strobes/lane replication with alignment check,
// and load-word extraction with sign or zero extension.
module lsu_align
   import lsu_pkg::*;
(
   input  logic [2:0]  memop,
   input  logic [1:0]  off,
   input  logic [31:0] wdata,
   input  logic [31:0] rdata,
   output logic [3:0]  wstrb,
   output logic [31:0] lane_wdata,
   output logic        misaligned,
   output logic [31:0] load_data
);

   logic [31:0] shifted;

   // Store path: replicate the operand into every lane it may land in and
   // enable only the addressed bytes.
   always_comb begin
      wstrb      = 4'b0000;
      lane_wdata = wdata;
      misaligned = 1'b0;
      case (memop)
         MOP_B, MOP_BU: begin
            wstrb      = 4'b0001 << off;
            lane_wdata = {4{wdata[7:0]}};
         end
         MOP_H, MOP_HU: begin
            wstrb      = 4'b0011 << off;
            lane_wdata = {2{wdata[15:0]}};
            misaligned = off[0];
         end
         MOP_W: begin
            wstrb      = 4'b1111;
            misaligned = (off != 2'b00);
         end
         default: ;
      endcase
   end

   // Load path: bring the addressed byte/half down to bit 0, then extend.
   always_comb begin
      shifted   = rdata >> {off, 3'b000};
      load_data = 32'h0;
      case (memop)
         MOP_B:   load_data = {{24{shifted[7]}}, shifted[7:0]};
         MOP_BU:  load_data = {24'h0, shifted[7:0]};
         MOP_H:   load_data = {{16{shifted[15]}}, shifted[15:0]};
         MOP_HU:  load_data = {16'h0, shifted[15:0]};
         MOP_W:   load_data = shifted;
         default: load_data = 32'h0;
      endcase
   end

endmodule

// File: rtl/lsu.sv
// Load/store unit: one access at a time, IDLE -> REQ -> WAIT -> DONE, with
// illegal/misaligned/no-op accesses bypassing the bus straight to DONE.
module lsu
   import lsu_pkg::*;
#(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [ADDR_W-1:0] in_addr,
   input  logic [DATA_W-1:0] in_wdata,
   input  logic [2:0]        in_memop,
   input  logic              in_memwr,
   input  logic              in_memtoreg,
   output logic              mem_req_valid,
   input  logic              mem_req_ready,
   output logic [ADDR_W-1:0] mem_req_addr,
   output logic              mem_req_we,
   output logic [3:0]        mem_req_wstrb,
   output logic [DATA_W-1:0] mem_req_wdata,
   input  logic              mem_rsp_valid,
   input  logic [DATA_W-1:0] mem_rsp_rdata,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_rdata,
   output logic              out_err
);

   state_e            state_q, state_d;
   kind_e             kind_q, kind_d;
   logic [2:0]        memop_q, memop_d;
   logic [1:0]        off_q, off_d;
   logic              in_ready_q, in_ready_d;
   logic              req_valid_q, req_valid_d;
   logic [ADDR_W-1:0] req_addr_q, req_addr_d;
   logic              req_we_q, req_we_d;
   logic [3:0]        req_wstrb_q, req_wstrb_d;
   logic [DATA_W-1:0] req_wdata_q, req_wdata_d;
   logic              out_valid_q, out_valid_d;
   logic [DATA_W-1:0] out_rdata_q, out_rdata_d;
   logic              out_err_q, out_err_d;

   kind_e       acc_kind;
   logic        illegal;
   logic [2:0]  sel_memop;
   logic [1:0]  sel_off;
   logic [3:0]  st_wstrb;
   logic [31:0] st_wdata;
   logic        st_misaligned;
   logic [31:0] ld_data;

   // In IDLE the aligner classifies the incoming access; afterwards it
   // extracts load data using the latched op and offset.
   assign sel_memop = (state_q == IDLE) ? in_memop : memop_q;
   assign sel_off   = (state_q == IDLE) ? in_addr[1:0] : off_q;

   lsu_align u_align (
      .memop      (sel_memop),
      .off        (sel_off),
      .wdata      (in_wdata),
      .rdata      (mem_rsp_rdata),
      .wstrb      (st_wstrb),
      .lane_wdata (st_wdata),
      .misaligned (st_misaligned),
      .load_data  (ld_data)
   );

   // Next-state and next-output logic; every output is registered.
   always_comb begin
      state_d     = state_q;
      kind_d      = kind_q;
      memop_d     = memop_q;
      off_d       = off_q;
      in_ready_d  = in_ready_q;
      req_valid_d = req_valid_q;
      req_addr_d  = req_addr_q;
      req_we_d    = req_we_q;
      req_wstrb_d = req_wstrb_q;
      req_wdata_d = req_wdata_q;
      out_valid_d = out_valid_q;
      out_rdata_d = out_rdata_q;
      out_err_d   = out_err_q;

      // A store wins when both memwr and memtoreg are set.
      acc_kind = in_memwr ? STORE : (in_memtoreg ? LOAD : NONE);
      illegal  = mop_undefined(in_memop) ||
                 ((acc_kind == STORE) && ((in_memop == MOP_BU) || (in_memop == MOP_HU)));

      case (state_q)
         IDLE: begin
            if (in_valid) begin
               memop_d    = in_memop;
               off_d      = in_addr[1:0];
               kind_d     = acc_kind;
               in_ready_d = 1'b0;
               if ((acc_kind == NONE) || (in_memop == MOP_NONE)) begin
                  state_d     = DONE;
                  out_valid_d = 1'b1;
                  out_err_d   = 1'b0;
                  out_rdata_d = '0;
               end else if (illegal || st_misaligned) begin
                  state_d     = DONE;
                  out_valid_d = 1'b1;
                  out_err_d   = 1'b1;
                  out_rdata_d = '0;
               end else begin
                  state_d     = REQ;
                  req_valid_d = 1'b1;
                  req_addr_d  = {in_addr[ADDR_W-1:2], 2'b00};
                  req_we_d    = (acc_kind == STORE);
                  req_wstrb_d = (acc_kind == STORE) ? st_wstrb : 4'b0000;
                  req_wdata_d = (acc_kind == STORE) ? st_wdata : '0;
               end
            end
         end
         REQ: begin
            if (mem_req_ready) begin
               req_valid_d = 1'b0;
               state_d     = WAIT;
            end
         end
         WAIT: begin
            if (mem_rsp_valid) begin
               state_d     = DONE;
               out_valid_d = 1'b1;
               out_err_d   = 1'b0;
               out_rdata_d = (kind_q == LOAD) ? ld_data : '0;
            end
         end
         DONE: begin
            if (out_ready) begin
               state_d     = IDLE;
               out_valid_d = 1'b0;
               in_ready_d  = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State and output registers; reset abandons any transfer in flight.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         kind_q      <= NONE;
         memop_q     <= MOP_NONE;
         off_q       <= 2'b00;
         in_ready_q  <= 1'b1;
         req_valid_q <= 1'b0;
         req_addr_q  <= '0;
         req_we_q    <= 1'b0;
         req_wstrb_q <= 4'b0000;
         req_wdata_q <= '0;
         out_valid_q <= 1'b0;
         out_rdata_q <= '0;
         out_err_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         kind_q      <= kind_d;
         memop_q     <= memop_d;
         off_q       <= off_d;
         in_ready_q  <= in_ready_d;
         req_valid_q <= req_valid_d;
         req_addr_q  <= req_addr_d;
         req_we_q    <= req_we_d;
         req_wstrb_q <= req_wstrb_d;
         req_wdata_q <= req_wdata_d;
         out_valid_q <= out_valid_d;
         out_rdata_q <= out_rdata_d;
         out_err_q   <= out_err_d;
      end
   end

   assign in_ready      = in_ready_q;
   assign mem_req_valid = req_valid_q;
   assign mem_req_addr  = req_addr_q;
   assign mem_req_we    = req_we_q;
   assign mem_req_wstrb = req_wstrb_q;
   assign mem_req_wdata = req_wdata_q;
   assign out_valid     = out_valid_q;
   assign out_rdata     = out_rdata_q;
   assign out_err       = out_err_q;

endmodule
